// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM/WB pipeline: control-bit indices,
// write-back select encodings and the pipeline bundle layout.
package mem_wb_pipe_pkg;

  localparam int unsigned CTRL_W = 5;

  // Bit positions inside the 5-bit MEM_WB_Ctrl word
  localparam int unsigned CTRL_REGWRITE    = 0;
  localparam int unsigned CTRL_MEMTOREG_LO = 1;
  localparam int unsigned CTRL_HALFBYTE    = 3;
  localparam int unsigned CTRL_JR          = 4;

  // MemToReg encodings (2'b11 also selects the ALU result)
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  // Default-width bundle layout; the top mirrors this layout at its own widths
  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_RADDR_W = 5;

  typedef struct packed {
    logic                   valid;
    logic [CTRL_W-1:0]      ctrl;
    logic [DEF_XLEN-1:0]    read;
    logic [DEF_XLEN-1:0]    pc4;
    logic [DEF_XLEN-1:0]    alu;
    logic [DEF_RADDR_W-1:0] rd;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wb_pipe_slot.sv
// pipe_stage_slot: one bundle register with reset, flush and stall.
// Ports: Clk/Reset (sync, active-high), Flush, Stall,
//        in_valid/in_data (from previous stage), valid/data (registered).
module pipe_stage_slot #(
  parameter int unsigned W = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Flush,
  input  logic         Stall,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);

  // Reset > Flush > Stall > advance; flush only drops valid, data is don't-care
  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (Flush) begin
      valid <= 1'b0;
    end else if (!Stall) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: STAGES-deep MEM/WB pipeline register with valid, stall,
// flush, r0 write suppression, write-back result mux and retire counter.
// Inputs:  Clk, Reset (sync, active-high), Stall, Flush, MEM_Valid,
//          MEM_WB_Ctrl, MEM_Read, PCAddResult, MEM_ALUResult, MEM_RegDst.
// Outputs: WB_* final-stage fields (gated RegWrite/jr), WB_Result,
//          WB_RetireCount.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned STAGES  = 1,   // legal 1..4
  parameter int unsigned CNT_W   = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               MEM_Valid,
  input  logic [CTRL_W-1:0]  MEM_WB_Ctrl,
  input  logic [XLEN-1:0]    MEM_Read,
  input  logic [XLEN-1:0]    PCAddResult,
  input  logic [XLEN-1:0]    MEM_ALUResult,
  input  logic [RADDR_W-1:0] MEM_RegDst,
  output logic               WB_Valid,
  output logic               WB_RegWrite,
  output logic [1:0]         WB_MemToReg,
  output logic               WB_halfbyte,
  output logic               WB_jr,
  output logic [XLEN-1:0]    WB_PCAddResult,
  output logic [XLEN-1:0]    WB_Read,
  output logic [XLEN-1:0]    WB_ALUResult,
  output logic [RADDR_W-1:0] WB_RegDst,
  output logic [XLEN-1:0]    WB_Result,
  output logic [CNT_W-1:0]   WB_RetireCount
);

  // Bundle payload (valid travels separately so flush can clear it alone)
  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [XLEN-1:0]    read;
    logic [XLEN-1:0]    pc4;
    logic [XLEN-1:0]    alu;
    logic [RADDR_W-1:0] rd;
  } payload_t;

  localparam int unsigned PAY_W = $bits(payload_t);

  logic     stg_valid [STAGES+1];
  payload_t stg_data  [STAGES+1];
  payload_t fin;
  logic     retire;
  logic [CNT_W-1:0] retire_cnt;

  assign stg_valid[0] = MEM_Valid;
  assign stg_data[0]  = '{ctrl: MEM_WB_Ctrl, read: MEM_Read, pc4: PCAddResult,
                          alu: MEM_ALUResult, rd: MEM_RegDst};

  // Register chain; index STAGES is the final (write-back) stage
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [PAY_W-1:0] slot_q;

    pipe_stage_slot #(.W(PAY_W)) u_slot (
      .Clk      (Clk),
      .Reset    (Reset),
      .Flush    (Flush),
      .Stall    (Stall),
      .in_valid (stg_valid[g]),
      .in_data  (stg_data[g]),
      .valid    (stg_valid[g+1]),
      .data     (slot_q)
    );

    assign stg_data[g+1] = slot_q;
  end

  assign fin = stg_data[STAGES];

  // Raw final-stage fields and gated enables
  assign WB_Valid       = stg_valid[STAGES];
  assign WB_MemToReg    = fin.ctrl[CTRL_MEMTOREG_LO +: 2];
  assign WB_halfbyte    = fin.ctrl[CTRL_HALFBYTE];
  assign WB_PCAddResult = fin.pc4;
  assign WB_Read        = fin.read;
  assign WB_ALUResult   = fin.alu;
  assign WB_RegDst      = fin.rd;
  assign WB_RegWrite    = WB_Valid & fin.ctrl[CTRL_REGWRITE] & (fin.rd != '0);
  assign WB_jr          = WB_Valid & fin.ctrl[CTRL_JR];

  // Write-back data select; halfword loads are sign-extended from bit 15
  always_comb begin
    WB_Result = fin.alu;
    case (WB_MemToReg)
      WB_SEL_MEM: WB_Result = fin.ctrl[CTRL_HALFBYTE]
                              ? XLEN'($signed(fin.read[15:0])) : fin.read;
      WB_SEL_PC:  WB_Result = fin.pc4;
      default:    WB_Result = fin.alu;
    endcase
  end

  // Count once, at the moment a valid entry is written into the final stage
  assign retire = !Flush && !Stall && stg_valid[STAGES-1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign WB_RetireCount = retire_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe with STAGES=2, CNT_W=4.
module tb_mem_wb_pipe;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned STAGES  = 2;
  localparam int unsigned CNT_W   = 4;

  logic               Clk = 1'b0;
  logic               Reset, Stall, Flush, MEM_Valid;
  logic [4:0]         MEM_WB_Ctrl;
  logic [XLEN-1:0]    MEM_Read, PCAddResult, MEM_ALUResult;
  logic [RADDR_W-1:0] MEM_RegDst;
  logic               WB_Valid, WB_RegWrite, WB_halfbyte, WB_jr;
  logic [1:0]         WB_MemToReg;
  logic [XLEN-1:0]    WB_PCAddResult, WB_Read, WB_ALUResult, WB_Result;
  logic [RADDR_W-1:0] WB_RegDst;
  logic [CNT_W-1:0]   WB_RetireCount;

  int n_tests = 0;
  int n_fail  = 0;

  mem_wb_pipe #(.XLEN(XLEN), .RADDR_W(RADDR_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush), .MEM_Valid(MEM_Valid),
    .MEM_WB_Ctrl(MEM_WB_Ctrl), .MEM_Read(MEM_Read), .PCAddResult(PCAddResult),
    .MEM_ALUResult(MEM_ALUResult), .MEM_RegDst(MEM_RegDst),
    .WB_Valid(WB_Valid), .WB_RegWrite(WB_RegWrite), .WB_MemToReg(WB_MemToReg),
    .WB_halfbyte(WB_halfbyte), .WB_jr(WB_jr), .WB_PCAddResult(WB_PCAddResult),
    .WB_Read(WB_Read), .WB_ALUResult(WB_ALUResult), .WB_RegDst(WB_RegDst),
    .WB_Result(WB_Result), .WB_RetireCount(WB_RetireCount)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] rd_data,
                       input logic [31:0] pc4, input logic [31:0] alu, input logic [4:0] rd);
    MEM_Valid = v; MEM_WB_Ctrl = c; MEM_Read = rd_data;
    PCAddResult = pc4; MEM_ALUResult = alu; MEM_RegDst = rd;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    tick(); tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Stall = 1'b1; Flush = 1'b1;
    drive(1'b1, 5'b11111, 32'hFFFF_FFFF, 32'h1111_1111, 32'h2222_2222, 5'd9);
    tick(); tick();
    n_tests++; if (WB_Valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %h exp 0", WB_Valid); end
    n_tests++; if (WB_RegWrite !== 1'b0) begin n_fail++; $display("FAIL rst_regwrite got %h exp 0", WB_RegWrite); end
    n_tests++; if (WB_Result !== 32'h0) begin n_fail++; $display("FAIL rst_result got %h exp 0", WB_Result); end
    n_tests++; if (WB_RetireCount !== 4'h0) begin n_fail++; $display("FAIL rst_count got %h exp 0", WB_RetireCount); end
    n_tests++; if ({WB_MemToReg, WB_halfbyte, WB_jr, WB_RegDst} !== 9'h0) begin n_fail++;
      $display("FAIL rst_ctrl got %h exp 0", {WB_MemToReg, WB_halfbyte, WB_jr, WB_RegDst}); end
    n_tests++; if ({WB_Read, WB_ALUResult, WB_PCAddResult} !== 96'h0) begin n_fail++;
      $display("FAIL rst_data got %h exp 0", {WB_Read, WB_ALUResult, WB_PCAddResult}); end
    Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
  endtask

  task automatic test_latency();
    do_reset();
    drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'h0000_1234, 5'd5);
    tick();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    n_tests++; if (WB_Valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid got %h exp 0", WB_Valid); end
    tick();
    n_tests++; if (WB_Valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %h exp 1", WB_Valid); end
    n_tests++; if (WB_RegWrite !== 1'b1) begin n_fail++; $display("FAIL lat_regwrite got %h exp 1", WB_RegWrite); end
    n_tests++; if (WB_Result !== 32'h0000_1234) begin n_fail++; $display("FAIL lat_result got %h exp 00001234", WB_Result); end
    n_tests++; if (WB_RegDst !== 5'd5) begin n_fail++; $display("FAIL lat_rd got %h exp 05", WB_RegDst); end
    n_tests++; if (WB_RetireCount !== 4'd1) begin n_fail++; $display("FAIL lat_count got %h exp 1", WB_RetireCount); end
  endtask

  task automatic test_result_mux();
    do_reset();
    drive(1'b1, 5'b01011, 32'h0000_8001, 32'h0000_0040, 32'h0000_0077, 5'd3);
    tick();
    drive(1'b1, 5'b00011, 32'h0000_8001, 32'h0000_0040, 32'h0000_0077, 5'd3);
    tick();
    n_tests++; if (WB_Result !== 32'hFFFF_8001) begin n_fail++; $display("FAIL mux_half got %h exp ffff8001", WB_Result); end
    n_tests++; if (WB_halfbyte !== 1'b1) begin n_fail++; $display("FAIL mux_halfflag got %h exp 1", WB_halfbyte); end
    drive(1'b1, 5'b00101, 32'h0000_8001, 32'h0000_0040, 32'h0000_0077, 5'd3);
    tick();
    n_tests++; if (WB_Result !== 32'h0000_8001) begin n_fail++; $display("FAIL mux_word got %h exp 00008001", WB_Result); end
    drive(1'b1, 5'b00111, 32'h0000_8001, 32'h0000_0040, 32'h0000_0077, 5'd3);
    tick();
    n_tests++; if (WB_Result !== 32'h0000_0040) begin n_fail++; $display("FAIL mux_pc got %h exp 00000040", WB_Result); end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    n_tests++; if (WB_Result !== 32'h0000_0077) begin n_fail++; $display("FAIL mux_alu11 got %h exp 00000077", WB_Result); end
    n_tests++; if (WB_RetireCount !== 4'd4) begin n_fail++; $display("FAIL mux_count got %h exp 4", WB_RetireCount); end
  endtask

  task automatic test_r0_suppress();
    do_reset();
    drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    n_tests++; if (WB_Valid !== 1'b1) begin n_fail++; $display("FAIL r0_valid got %h exp 1", WB_Valid); end
    n_tests++; if (WB_RegWrite !== 1'b0) begin n_fail++; $display("FAIL r0_regwrite got %h exp 0", WB_RegWrite); end
    n_tests++; if (WB_Result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL r0_result got %h exp deadbeef", WB_Result); end
    n_tests++; if (WB_RetireCount !== 4'd1) begin n_fail++; $display("FAIL r0_count got %h exp 1", WB_RetireCount); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'h0000_00AA, 5'd1);
    tick();
    drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'h0000_00BB, 5'd2);
    tick();
    drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'h0000_00CC, 5'd3);
    tick();
    n_tests++; if (WB_ALUResult !== 32'hBB) begin n_fail++; $display("FAIL stall_b_pre got %h exp bb", WB_ALUResult); end
    // An input presented during the stall must not be captured
    Stall = 1'b1;
    drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'h0000_00EE, 5'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (WB_Valid !== 1'b1 || WB_ALUResult !== 32'hBB || WB_RegDst !== 5'd2) begin n_fail++;
        $display("FAIL stall_hold%0d got v=%h alu=%h rd=%h exp v=1 alu=bb rd=02", i, WB_Valid, WB_ALUResult, WB_RegDst); end
      n_tests++; if (WB_RetireCount !== 4'd2) begin n_fail++; $display("FAIL stall_cnt%0d got %h exp 2", i, WB_RetireCount); end
    end
    Stall = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    n_tests++; if (WB_Valid !== 1'b1 || WB_ALUResult !== 32'hCC) begin n_fail++;
      $display("FAIL stall_c got v=%h alu=%h exp v=1 alu=cc", WB_Valid, WB_ALUResult); end
    tick();
    n_tests++; if (WB_Valid !== 1'b0) begin n_fail++; $display("FAIL stall_drop got %h exp 0", WB_Valid); end
    n_tests++; if (WB_RetireCount !== 4'd3) begin n_fail++; $display("FAIL stall_final_cnt got %h exp 3", WB_RetireCount); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(1'b1, 5'b10001, 32'h0, 32'h0, 32'h0000_0011, 5'd7);
    tick();
    drive(1'b1, 5'b10001, 32'h0, 32'h0, 32'h0000_0022, 5'd8);
    tick();
    n_tests++; if (WB_jr !== 1'b1) begin n_fail++; $display("FAIL fl_jr_pre got %h exp 1", WB_jr); end
    Stall = 1'b1; Flush = 1'b1;
    drive(1'b1, 5'b10001, 32'h0, 32'h0, 32'h0000_0033, 5'd9);
    tick();
    n_tests++; if ({WB_Valid, WB_RegWrite, WB_jr} !== 3'b000) begin n_fail++;
      $display("FAIL fl_gate got %b exp 000", {WB_Valid, WB_RegWrite, WB_jr}); end
    n_tests++; if (WB_RetireCount !== 4'd1) begin n_fail++; $display("FAIL fl_cnt got %h exp 1", WB_RetireCount); end
    Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick();
    n_tests++; if (WB_Valid !== 1'b0) begin n_fail++; $display("FAIL fl_next_valid got %h exp 0", WB_Valid); end
    n_tests++; if (WB_RetireCount !== 4'd1) begin n_fail++; $display("FAIL fl_next_cnt got %h exp 1", WB_RetireCount); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 5'b00001, 32'h0, 32'h0, 32'(i), 5'd4);
      tick();
    end
    n_tests++; if (WB_RetireCount !== 4'd0) begin n_fail++; $display("FAIL wrap_16 got %h exp 0", WB_RetireCount); end
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    tick(); tick();
    n_tests++; if (WB_RetireCount !== 4'd1) begin n_fail++; $display("FAIL wrap_17 got %h exp 1", WB_RetireCount); end
    drive(1'b1, 5'b11111, 32'h1234_5678, 32'h0000_0100, 32'h0000_0200, 5'd6);
    tick(); tick();
    n_tests++; if (WB_Valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got %h exp 1", WB_Valid); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    n_tests++; if ({WB_Valid, WB_RegWrite, WB_jr, WB_halfbyte, WB_MemToReg, WB_RegDst} !== 11'h0) begin n_fail++;
      $display("FAIL midrst_ctrl got %h exp 0", {WB_Valid, WB_RegWrite, WB_jr, WB_halfbyte, WB_MemToReg, WB_RegDst}); end
    n_tests++; if ({WB_Result, WB_Read, WB_ALUResult, WB_PCAddResult} !== 128'h0) begin n_fail++;
      $display("FAIL midrst_data got %h exp 0", {WB_Result, WB_Read, WB_ALUResult, WB_PCAddResult}); end
    n_tests++; if (WB_RetireCount !== 4'd0) begin n_fail++; $display("FAIL midrst_cnt got %h exp 0", WB_RetireCount); end
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
    test_reset();
    test_latency();
    test_result_mux();
    test_r0_suppress();
    test_stall();
    test_flush_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
- Parametrised successor to the MEM/WB pipeline register.
- Carries the memory-stage result bundle through a configurable number of register stages (STAGES) into write-back.
- Adds over the single-stage register: per-entry valid, stall (hold), flush (bubble), r0 write suppression, a write-back result mux and a retired-instruction counter.
- Sits between the data-memory stage and the register-file write port / forwarding unit.

Parameters:
- XLEN, 32, datapath width of Read/ALU/PC+4 values.
- RADDR_W, 5, destination register address width.
- STAGES, 1, number of register stages; legal range 1..4.
- CNT_W, 32, retire counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold all stages.
- Flush  in  1  invalidate all stages.
- MEM_Valid  in  1  incoming bundle valid.
- MEM_WB_Ctrl  in  5  [0] RegWrite, [2:1] MemToReg, [3] halfbyte, [4] jr.
- MEM_Read  in  XLEN  memory read data.
- PCAddResult  in  XLEN  PC+4.
- MEM_ALUResult  in  XLEN  ALU result.
- MEM_RegDst  in  RADDR_W  destination register.
- WB_Valid  out  1  final-stage valid.
- WB_RegWrite  out  1  gated register write enable.
- WB_MemToReg  out  2  final-stage select.
- WB_halfbyte  out  1  final-stage halfbyte flag.
- WB_jr  out  1  gated jr flag.
- WB_PCAddResult, WB_Read, WB_ALUResult  out  XLEN  final-stage values.
- WB_RegDst  out  RADDR_W  final-stage destination register.
- WB_Result  out  XLEN  selected write-back data.
- WB_RetireCount  out  CNT_W  count of valid entries retired.

Behaviour:
- All clocked logic updates on posedge Clk only.
- Reset=1: every stage's valid, ctrl and data fields clear to 0; WB_RetireCount=0. All outputs therefore read 0, including WB_Result=0. Reset overrides Stall and Flush. Reset asserted mid-stream discards all in-flight entries.
- Priority order: Reset > Flush > Stall > normal advance.
- Flush=1 (no Reset): every stage's valid clears to 0. Data fields may keep old values. The input bundle is dropped. The counter does not increment.
- Stall=1 (no Reset/Flush): all stages hold. The input bundle is not captured. The counter holds.
- Normal advance: stage0 <= {MEM_Valid, ctrl, data}; stage k <= stage k-1. Latency is exactly STAGES cycles from input to WB_* outputs.
- MEM_Valid=0 inserts a bubble. A bubble travels with valid=0 and its data is don't-care.
- Output gating (combinational from the final stage):
  - WB_RegWrite = valid & RegWrite & (RegDst != 0).
  - WB_jr = valid & jr.
  - WB_MemToReg, WB_halfbyte and the data outputs are raw final-stage fields.
- WB_Result selection by MemToReg:
  - 00: ALUResult.
  - 01: Read; when halfbyte=1, Read[15:0] sign-extended to XLEN.
  - 10: PCAddResult.
  - 11: ALUResult.
- Retire counter: increments by 1 on a cycle with Reset=0, Flush=0, Stall=0 and a valid entry being written into the final stage. Wraps modulo 2^CNT_W with no saturation. Each instruction is counted exactly once, even if it is then held by Stall.
- Stall and Flush together: Flush wins; the stages are invalidated, not held.
- STAGES=1: the block is equivalent to the single-stage register plus valid/stall/flush gating.

Decomposition:
- Shared package (pipeline pkg):
  - Ctrl bit-index constants: CTRL_REGWRITE=0, CTRL_MEMTOREG_LO=1, CTRL_HALFBYTE=3, CTRL_JR=4.
  - MemToReg encodings: WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_PC=2'b10.
  - The packed wb_bundle typedef {valid, ctrl, read, pc4, alu, rd}.
- One sub-module is natural: pipe_stage_slot, a single bundle register with reset/flush/stall. It is instantiated STAGES times via generate.
- The result mux and counter stay in the top level.

Test Plan:
- STAGES=2; Reset 2 cycles, then MEM_Valid=1, ctrl=5'b00001, ALU=0x0000_1234, RegDst=5. After exactly 2 clocks: WB_Valid=1, WB_RegWrite=1, WB_Result=0x1234, WB_RetireCount=1.
- ctrl=5'b01011 (MemToReg=01, halfbyte=1), Read=0x0000_8001, RegDst=3 → WB_Result=0xFFFF_8001. With halfbyte=0 → WB_Result=0x0000_8001.
- RegWrite=1, RegDst=0, ALU=0xDEAD_BEEF → WB_Valid=1, WB_RegWrite=0, counter increments.
- Stream A, B, C back-to-back; Stall held for 3 cycles while B is in the final stage → WB outputs hold B for 3 cycles; C appears on the first cycle after Stall drops; counter ends at 3, not 5.
- Stall=1 and Flush=1 in the same cycle with 2 valid entries in flight → next cycle WB_Valid=0, WB_RegWrite=0, WB_jr=0; counter unchanged.
- CNT_W=4; retire 17 valid entries → WB_RetireCount=1 (wrap). Assert Reset mid-stream → all outputs 0 on the next cycle.
